// File: rtl/datapath_p2_pkg.sv
// Shared constants for the single-bus CPU datapath: widths, ALU opcodes, CON condition codes.
package datapath_p2_pkg;
  localparam int DW        = 32;
  localparam int RAM_DEPTH = 512;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;

  localparam logic [1:0] CON_EQZ = 2'b00;
  localparam logic [1:0] CON_NEZ = 2'b01;
  localparam logic [1:0] CON_GEZ = 2'b10;
  localparam logic [1:0] CON_LTZ = 2'b11;
endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A=Y, B=bus, 64-bit result. Signed divide only when DIV_EN is defined.
module datapath_alu
  import datapath_p2_pkg::*;
(
  input  logic [4:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          inc_pc,
  output logic [63:0]   res
);
  logic [4:0] sh;
  logic [5:0] rsh;

  assign sh  = b[4:0];
  assign rsh = 6'd32 - {1'b0, sh};

  always_comb begin
    res = '0;
    if (inc_pc) begin
      res = {32'b0, b + 32'd1};
    end else begin
      case (op)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BR: res = {32'b0, a + b};
        OP_SUB:          res = {32'b0, a - b};
        OP_SHR:          res = {32'b0, a >> sh};
        OP_SHL:          res = {32'b0, a << sh};
        // a shift of 32 yields 0, so a zero rotate amount falls out naturally
        OP_ROR:          res = {32'b0, (a >> sh) | (a << rsh)};
        OP_ROL:          res = {32'b0, (a << sh) | (a >> rsh)};
        OP_AND, OP_ANDI: res = {32'b0, a & b};
        OP_OR, OP_ORI:   res = {32'b0, a | b};
        OP_MUL:          res = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        OP_DIV: begin
`ifdef DIV_EN
          if (b != '0)
            res = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
`endif
        end
        OP_NEG:          res = {32'b0, -b};
        OP_NOT:          res = {32'b0, ~b};
        default:         res = {32'b0, b};
      endcase
    end
  end
endmodule

// File: rtl/datapath_p2.sv
// Single-bus CPU datapath: GPRs, special registers, bus mux, select/encode, CON, RAM.
// Optional signed divider via DIV_EN.
module datapath_p2
  import datapath_p2_pkg::*;
(
  input  logic          Clock,
  input  logic          Clear,
  output logic [DW-1:0] outp,
  input  logic          PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout,
  input  logic          MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
  input  logic          IncPC, Read, Write,
  input  logic          ExtOpEn,
  input  logic          Gra, Grb, Grc, Rin, Rout, BAout,
  input  logic          Cout, CONIn,
  input  logic          Strobe,
  input  logic [DW-1:0] Mdatain,
  input  logic [DW-1:0] InputDev,
  input  logic [4:0]    ExtOp,
  input  logic          MemSel
);
  localparam int AW = $clog2(RAM_DEPTH);

  logic [DW-1:0] gpr [16];
  logic [DW-1:0] pc, ir, mar, mdr, y, hi, lo, inport, outport;
  logic [63:0]   z, alu_res;
  logic          con, con_next;
  logic [DW-1:0] bus, c_ext, mdr_in;
  logic [3:0]    sel;
  logic [4:0]    opcode;
  logic [DW-1:0] ram [RAM_DEPTH];

  assign sel    = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign c_ext  = {{13{ir[18]}}, ir[18:0]};
  assign opcode = ExtOpEn ? ExtOp : ir[31:27];
  assign mdr_in = Read ? (MemSel ? ram[mar[AW-1:0]] : Mdatain) : bus;
  assign outp   = outport;

  always_comb begin
    bus = '0;
    if (Rout || BAout)  bus = (BAout && sel == 4'd0) ? '0 : gpr[sel];
    else if (HIout)     bus = hi;
    else if (LOout)     bus = lo;
    else if (Zhiout)    bus = z[63:32];
    else if (Zlowout)   bus = z[31:0];
    else if (PCout)     bus = pc;
    else if (MDRout)    bus = mdr;
    else if (InPortout) bus = inport;
    else if (Cout)      bus = c_ext;
  end

  always_comb begin
    case (ir[20:19])
      CON_EQZ: con_next = (bus == '0);
      CON_NEZ: con_next = (bus != '0);
      CON_GEZ: con_next = ~bus[DW-1];
      default: con_next = bus[DW-1];
    endcase
  end

  datapath_alu u_alu (
    .op     (opcode),
    .a      (y),
    .b      (bus),
    .inc_pc (IncPC),
    .res    (alu_res)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
      pc      <= '0;
      ir      <= '0;
      mar     <= '0;
      mdr     <= '0;
      y       <= '0;
      z       <= '0;
      hi      <= '0;
      lo      <= '0;
      inport  <= '0;
      outport <= '0;
      con     <= 1'b0;
    end else begin
      if (Rin)       gpr[sel] <= bus;
      if (PCin)      pc       <= bus;
      if (IRin)      ir       <= bus;
      if (MARin)     mar      <= bus;
      if (MDRin)     mdr      <= mdr_in;
      if (Yin)       y        <= bus;
      if (Zin)       z        <= alu_res;
      if (HIin)      hi       <= bus;
      if (LOin)      lo       <= bus;
      if (Strobe)    inport   <= InputDev;
      if (OutPortin) outport  <= bus;
      if (CONIn)     con      <= con_next;
    end
  end

  // RAM contents survive Clear
  always_ff @(posedge Clock) begin
    if (Write) ram[mar[AW-1:0]] <= mdr;
  end
endmodule

// File: tb/tb_datapath_p2.sv
// Directed bench for datapath_p2: control-step sequences with hand-computed results.
module tb_datapath_p2;
  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] outp;
  logic        PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
  logic        IncPC, Read, Write, ExtOpEn;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe, MemSel;
  logic [31:0] Mdatain, InputDev;
  logic [4:0]  ExtOp;

  int passed = 0;
  int total  = 0;

  always #5 Clock = ~Clock;

  datapath_p2 dut (
    .Clock(Clock), .Clear(Clear), .outp(outp),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .ExtOpEn(ExtOpEn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .CONIn(CONIn), .Strobe(Strobe),
    .Mdatain(Mdatain), .InputDev(InputDev), .ExtOp(ExtOp), .MemSel(MemSel)
  );

  task automatic idle();
    {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin} = '0;
    {IncPC, Read, Write, ExtOpEn, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {Cout, CONIn, Strobe, MemSel} = '0;
    ExtOp = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic load_ir(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1; tick();
    MDRout = 1; IRin = 1; tick();
  endtask

  task automatic strobe_in(input logic [31:0] v);
    InputDev = v; Strobe = 1; tick();
  endtask

  task automatic alu_ext(input logic [4:0] op);
    Grb = 1; Rout = 1; Zin = 1; ExtOpEn = 1; ExtOp = op; tick();
  endtask

  initial begin
    idle();
    Mdatain = '0; InputDev = '0;
    Clear = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_outp", {32'b0, outp}, 64'd0);
    chk("reset_pc",   {32'b0, dut.pc}, 64'd0);
    chk("reset_z",    dut.z, 64'd0);
    Clear = 1'b1;
    tick();

    // fetch: MAR<-PC, Z<-PC+1, PC<-Z
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
    chk("fetch_mar", {32'b0, dut.mar}, 64'd0);
    chk("fetch_z",   dut.z, 64'd1);
    Zlowout = 1; PCin = 1; tick();
    chk("fetch_pc", {32'b0, dut.pc}, 64'd1);

    load_ir(32'hB080_0000);
    chk("ir_load", {32'b0, dut.ir}, 64'h0000_0000_B080_0000);

    strobe_in(32'd24);
    InPortout = 1; Gra = 1; Rin = 1; tick();
    chk("r1_in", {32'b0, dut.gpr[1]}, 64'd24);
    Gra = 1; Rout = 1; OutPortin = 1; tick();
    chk("out_r1", {32'b0, outp}, 64'd24);

    // add R?, R2, R3 with ra=2 rb=3 rc=4
    load_ir(32'h191A_0000);
    strobe_in(32'd7); InPortout = 1; Gra = 1; Rin = 1; tick();
    strobe_in(32'd5); InPortout = 1; Grb = 1; Rin = 1; tick();
    Gra = 1; Rout = 1; Yin = 1; tick();
    Grb = 1; Rout = 1; Zin = 1; tick();
    chk("add_z", dut.z, 64'd12);
    Zlowout = 1; OutPortin = 1; tick();
    chk("add_out", {32'b0, outp}, 64'd12);
    alu_ext(5'b00100); chk("sub_z", dut.z, 64'd2);
    alu_ext(5'b00110); chk("shl_z", dut.z, 64'h0000_0000_0000_00E0);
    alu_ext(5'b00111); chk("ror_z", dut.z, 64'h0000_0000_3800_0000);
    alu_ext(5'b10001); chk("not_z", dut.z, 64'h0000_0000_FFFF_FFFA);

    strobe_in(32'hFFFF_FFFD); InPortout = 1; Yin = 1; tick();
    alu_ext(5'b01110);
    chk("mul_z", dut.z, 64'hFFFF_FFFF_FFFF_FFF1);
    Zhiout = 1; OutPortin = 1; tick();
    chk("mul_hi_out", {32'b0, outp}, 64'h0000_0000_FFFF_FFFF);
    alu_ext(5'b01111);
`ifdef DIV_EN
    chk("div_z", dut.z, 64'hFFFF_FFFD_0000_0000);
`else
    chk("div_z", dut.z, 64'd0);
`endif

    // CON with IR[20:19]=00 (==0)
    load_ir(32'h0000_0000);
    CONIn = 1; tick();
    chk("con_eqz_1", {63'b0, dut.con}, 64'd1);
    strobe_in(32'd1); InPortout = 1; CONIn = 1; tick();
    chk("con_eqz_0", {63'b0, dut.con}, 64'd0);

    InPortout = 1; Gra = 1; Rin = 1; tick();
    chk("r0_in", {32'b0, dut.gpr[0]}, 64'd1);
    Gra = 1; BAout = 1; OutPortin = 1; tick();
    chk("baout_r0", {32'b0, outp}, 64'd0);
    Gra = 1; Rout = 1; OutPortin = 1; tick();
    chk("rout_r0", {32'b0, outp}, 64'd1);

    load_ir(32'h0004_0005);
    Cout = 1; OutPortin = 1; tick();
    chk("c_sext", {32'b0, outp}, 64'h0000_0000_FFFC_0005);
    load_ir(32'h001C_0000);
    Cout = 1; CONIn = 1; tick();
    chk("con_ltz", {63'b0, dut.con}, 64'd1);

    // RAM write then internal read
    strobe_in(32'h0000_01F3); InPortout = 1; MARin = 1; tick();
    strobe_in(32'hCAFE_0001); InPortout = 1; MDRin = 1; tick();
    Write = 1; tick();
    strobe_in(32'd0); InPortout = 1; MDRin = 1; tick();
    Read = 1; MemSel = 1; MDRin = 1; tick();
    MDRout = 1; OutPortin = 1; tick();
    chk("ram_rd", {32'b0, outp}, 64'h0000_0000_CAFE_0001);

    // HI beats LO on the bus
    strobe_in(32'h1234_5678); InPortout = 1; HIin = 1; tick();
    strobe_in(32'h0000_00AA); InPortout = 1; LOin = 1; tick();
    HIout = 1; LOout = 1; OutPortin = 1; tick();
    chk("hi_prio", {32'b0, outp}, 64'h0000_0000_1234_5678);
    LOout = 1; OutPortin = 1; tick();
    chk("lo_out", {32'b0, outp}, 64'h0000_0000_0000_00AA);

    // same-register drive and load: PC takes old PC (+0 via bus)
    PCout = 1; PCin = 1; tick();
    chk("pc_self", {32'b0, dut.pc}, 64'd1);

    #2 Clear = 1'b0; #1;
    chk("async_clr_outp", {32'b0, outp}, 64'd0);
    chk("async_clr_pc",   {32'b0, dut.pc}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
